// File: rtl/cdc_hs_tx_ctrl.sv
// cdc_hs_tx_ctrl
// Source-side controller for a 4-phase req/ack handshake carrying a
// DATA_W-bit word into another clock domain. The word is captured on
// accept and held on tx_data; only the returning ack crosses domains,
// through a SYNC_STAGES-deep flop chain.
//
// Build option: define CDC_HS_TIMEOUT_EN to abort a handshake wait state
// after TIMEOUT_CYC cycles. Without it both wait states wait forever and
// the timeout output is tied low.
//
// state  | meaning
// -------+---------------------------------------------------------------
// DRAIN  | after reset/abort: wait for the sync chain to settle with ack low
// IDLE   | ready for a new word; a high ack here is a protocol error
// REQ_HI | tx_req asserted, waiting for the synchronized ack to rise
// ACK_LO | tx_req released, waiting for the synchronized ack to fall

module cdc_hs_tx_ctrl #(
    parameter int DATA_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              tx_ack_async,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              timeout
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        DRAIN  = 2'd0,
        IDLE   = 2'd1,
        REQ_HI = 2'd2,
        ACK_LO = 2'd3
    } state_t;

    // A single-flop chain gives no metastability protection, and a wait
    // budget below two cycles cannot cover even the synchronizer delay.
    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 2) begin : gParamCheck
        $error("cdc_hs_tx_ctrl: SYNC_STAGES and TIMEOUT_CYC must both be >= 2");
    end

    state_t                state;
    state_t                nextState;
    logic [SYNC_STAGES-1:0] syncFf;
    logic                  ackS;
    logic [SETTLE_W-1:0]   settleCnt;
    logic                  settleDone;
    logic                  waitExpired;

    logic                  nxtReady;
    logic [DATA_W-1:0]     nxtData;
    logic                  nxtReq;
    logic                  nxtBusy;
    logic                  nxtDone;
    logic                  nxtErr;
    logic                  nxtTimeout;

    // Ack synchronizer: shift the asynchronous ack through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncFf <= '0;
        end else begin
            syncFf <= {syncFf[SYNC_STAGES-2:0], tx_ack_async};
        end
    end

    assign ackS = syncFf[SYNC_STAGES-1];

    // Settle counter: counts DRAIN cycles so stale ack values have flushed
    // out of the chain before the FSM trusts ackS; cleared outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            settleCnt <= '0;
        end else if (state != DRAIN) begin
            settleCnt <= '0;
        end else if (!settleDone) begin
            settleCnt <= settleCnt + SETTLE_W'(1);
        end
    end

    assign settleDone = (settleCnt == SETTLE_W'(SYNC_STAGES));

`ifdef CDC_HS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC);

    logic [WAIT_W-1:0] waitCnt;
    logic              ackMissing;

    // Wait counter: restarts on every state change, runs in the wait states.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
        end else if ((state != nextState) || !(state inside {REQ_HI, ACK_LO})) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
        end
    end

    assign ackMissing  = ((state == REQ_HI) && !ackS) || ((state == ACK_LO) && ackS);
    assign waitExpired = ackMissing && (waitCnt == WAIT_W'(TIMEOUT_CYC - 1));
`else
    assign waitExpired = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
            tx_data  <= '0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= nextState;
            in_ready <= nxtReady;
            tx_data  <= nxtData;
            tx_req   <= nxtReq;
            busy     <= nxtBusy;
            done     <= nxtDone;
            err      <= nxtErr;
            timeout  <= nxtTimeout;
        end
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            DRAIN: begin
                if (settleDone && !ackS) begin
                    nextState = IDLE;
                end
            end
            IDLE: begin
                if (in_valid && in_ready) begin
                    nextState = REQ_HI;
                end
            end
            REQ_HI: begin
                if (waitExpired) begin
                    nextState = DRAIN;
                end else if (ackS) begin
                    nextState = ACK_LO;
                end
            end
            ACK_LO: begin
                if (waitExpired) begin
                    nextState = DRAIN;
                end else if (!ackS) begin
                    nextState = IDLE;
                end
            end
            default: nextState = DRAIN;
        endcase
    end

    // Output decode: next values of the registered outputs; they hold by default.
    always_comb begin
        nxtReady   = in_ready;
        nxtData    = tx_data;
        nxtReq     = tx_req;
        nxtBusy    = busy;
        nxtDone    = 1'b0;
        nxtErr     = err;
        nxtTimeout = 1'b0;
        case (state)
            DRAIN: begin
                if (settleDone && !ackS) begin
                    nxtReady = 1'b1;
                end
            end
            IDLE: begin
                // The remote side has no request to acknowledge here.
                if (ackS) begin
                    nxtErr = 1'b1;
                end
                if (in_valid && in_ready) begin
                    nxtData  = in_data;
                    nxtReq   = 1'b1;
                    nxtReady = 1'b0;
                    nxtBusy  = 1'b1;
                end
            end
            REQ_HI: begin
                if (waitExpired) begin
                    nxtTimeout = 1'b1;
                    nxtReq     = 1'b0;
                    nxtBusy    = 1'b0;
                    nxtErr     = 1'b1;
                end else if (ackS) begin
                    nxtReq = 1'b0;
                end
            end
            ACK_LO: begin
                if (waitExpired) begin
                    nxtTimeout = 1'b1;
                    nxtBusy    = 1'b0;
                    nxtErr     = 1'b1;
                end else if (!ackS) begin
                    nxtDone  = 1'b1;
                    nxtBusy  = 1'b0;
                    nxtReady = 1'b1;
                end
            end
            default: begin
                nxtReady = 1'b0;
                nxtReq   = 1'b0;
                nxtBusy  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// tb_cdc_hs_tx_ctrl
// Randomized loopback traffic checked every cycle against a transaction-
// level model, followed by directed error, reset and timeout scenarios.
// Define CDC_HS_TIMEOUT_EN for both files to exercise the abort path.

module tb_cdc_hs_tx_ctrl;

    localparam int DW = 6;
    localparam int S  = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_req;
    logic          tx_ack_async;
    logic          busy;
    logic          done;
    logic          err;
    logic          timeout;

    logic ackLoop  = 1'b1;
    logic ackForce = 1'b0;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    // Reference model state (valid only while the ack is looped back).
    logic          modelOn = 1'b0;
    logic          mReady  = 1'b0;
    logic          mInFlight = 1'b0;
    logic [DW-1:0] mData   = '0;
    int            accEdge = 0;
    int            rstEdge = 0;

    always #5 clk = ~clk;

    always_comb tx_ack_async = ackLoop ? tx_req : ackForce;

    cdc_hs_tx_ctrl #(
        .DATA_W     (DW),
        .SYNC_STAGES(S),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .tx_ack_async(tx_ack_async),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .timeout     (timeout)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transaction view: after reset the word path opens S+1 edges later;
    // with the ack looped back, a word accepted at edge A holds tx_req for
    // edges A..A+S and completes (done) at edge A+2S+2.
    task automatic modelStep();
        logic mDone;
        logic mReq;
        mDone = 1'b0;
        if (rst) begin
            mInFlight = 1'b0;
            mData     = '0;
            rstEdge   = cyc;
        end else if (mInFlight && (cyc == accEdge + 2 * S + 2)) begin
            mDone     = 1'b1;
            mInFlight = 1'b0;
        end else if (!mInFlight && mReady && in_valid) begin
            mInFlight = 1'b1;
            accEdge   = cyc;
            mData     = in_data;
        end
        mReady = !mInFlight && !rst && (cyc >= rstEdge + S + 1);
        mReq   = mInFlight && (cyc <= accEdge + S);
        checkVal("m_in_ready", in_ready, mReady);
        checkVal("m_tx_req",   tx_req,   mReq);
        checkVal("m_tx_data",  tx_data,  mData);
        checkVal("m_busy",     busy,     mInFlight);
        checkVal("m_done",     done,     mDone);
        checkVal("m_err",      err,      1'b0);
        checkVal("m_timeout",  timeout,  1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (modelOn) modelStep();
    endtask

    task automatic doReset();
        ackLoop  = 1'b1;
        ackForce = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (S + 1) tick();
        checkVal("reset_ready", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a1;
        int  a2;
        logic found;
        logic prevReq;

        // Random loopback traffic with occasional resets.
        modelOn = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 149) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = DW'($urandom);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        modelOn = 1'b0;

        // Reset release and a single loopback word.
        rst = 1'b1;
        tick();
        tick();
        checkVal("rst_tx_req", tx_req, 1'b0);
        checkVal("rst_tx_data", tx_data, '0);
        checkVal("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        checkVal("rel_ready_e1", in_ready, 1'b0);
        tick();
        checkVal("rel_ready_e2", in_ready, 1'b0);
        tick();
        checkVal("rel_ready_e3", in_ready, 1'b1);
        checkVal("rel_err", err, 1'b0);
        in_valid = 1'b1;
        in_data  = 6'b110011;
        tick();
        in_valid = 1'b0;
        in_data  = 6'b000101;
        checkVal("lb_data", tx_data, 6'b110011);
        checkVal("lb_req0", tx_req, 1'b1);
        checkVal("lb_ready0", in_ready, 1'b0);
        checkVal("lb_busy0", busy, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkVal("lb_req", tx_req, (k <= 2));
            checkVal("lb_done", done, (k == 6));
            checkVal("lb_busy", busy, (k < 6));
            checkVal("lb_hold", tx_data, 6'b110011);
        end
        tick();
        checkVal("lb_done_once", done, 1'b0);

        // Back-to-back words with in_valid held.
        in_valid = 1'b1;
        in_data  = 6'h15;
        tick();
        a1 = cyc;
        checkVal("b2b_data1", tx_data, 6'h15);
        in_data = 6'h2A;
        found = 1'b0;
        a2 = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            prevReq = tx_req;
            tick();
            if (!prevReq && tx_req) begin
                found = 1'b1;
                a2 = cyc;
            end else if (busy) begin
                checkVal("b2b_hold", tx_data, 6'h15);
            end
        end
        checkVal("b2b_found", found, 1'b1);
        checkVal("b2b_period", a2 - a1, 7);
        checkVal("b2b_data2", tx_data, 6'h2A);
        in_valid = 1'b0;
        repeat (8) tick();
        checkVal("b2b_idle_busy", busy, 1'b0);
        checkVal("b2b_idle_ready", in_ready, 1'b1);

        // Ack high while idle: sticky error, no spontaneous transfer.
        ackLoop  = 1'b0;
        ackForce = 1'b1;
        tick();
        checkVal("err_e1", err, 1'b0);
        tick();
        checkVal("err_e2", err, 1'b0);
        tick();
        checkVal("err_e3", err, 1'b1);
        repeat (10) begin
            tick();
            checkVal("err_hold", err, 1'b1);
            checkVal("err_no_req", tx_req, 1'b0);
            checkVal("err_no_busy", busy, 1'b0);
        end
        ackForce = 1'b0;
        repeat (5) tick();
        checkVal("err_sticky", err, 1'b1);
        rst = 1'b1;
        tick();
        checkVal("err_cleared", err, 1'b0);
        rst = 1'b0;

        // Reset during REQ_HI with the remote ack held high.
        doReset();
        ackLoop  = 1'b0;
        ackForce = 1'b0;
        in_valid = 1'b1;
        in_data  = 6'h2D;
        tick();
        in_valid = 1'b0;
        ackForce = 1'b1;
        tick();
        checkVal("mid_req_hi", tx_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkVal("mid_req_drop", tx_req, 1'b0);
        checkVal("mid_data_rst", tx_data, '0);
        checkVal("mid_busy_rst", busy, 1'b0);
        repeat (8) begin
            tick();
            checkVal("mid_ready_held", in_ready, 1'b0);
        end
        ackForce = 1'b0;
        tick();
        checkVal("mid_rel_e1", in_ready, 1'b0);
        tick();
        checkVal("mid_rel_e2", in_ready, 1'b0);
        tick();
        checkVal("mid_rel_e3", in_ready, 1'b1);
        checkVal("mid_err", err, 1'b0);

        // Ack stuck low after a request.
        doReset();
        ackLoop  = 1'b0;
        ackForce = 1'b0;
        in_valid = 1'b1;
        in_data  = 6'h0F;
        tick();
        in_valid = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
        for (int k = 1; k < TO; k++) begin
            tick();
            checkVal("to_req_wait", tx_req, 1'b1);
            checkVal("to_quiet", timeout, 1'b0);
        end
        tick();
        checkVal("to_pulse", timeout, 1'b1);
        checkVal("to_req_drop", tx_req, 1'b0);
        checkVal("to_err", err, 1'b1);
        checkVal("to_busy", busy, 1'b0);
        checkVal("to_no_done", done, 1'b0);
        tick();
        checkVal("to_pulse_end", timeout, 1'b0);
        checkVal("to_drain_e1", in_ready, 1'b0);
        tick();
        checkVal("to_drain_e2", in_ready, 1'b0);
        tick();
        checkVal("to_drain_e3", in_ready, 1'b1);
        checkVal("to_err_sticky", err, 1'b1);
`else
        repeat (3 * TO) begin
            tick();
            checkVal("nto_req_held", tx_req, 1'b1);
            checkVal("nto_busy", busy, 1'b1);
            checkVal("nto_timeout", timeout, 1'b0);
        end
        checkVal("nto_err", err, 1'b0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
